// File: rtl/riscv_branch_resolve.sv
// Execute-stage branch resolution: evaluates two control-flow slots per cycle,
// feeds predictor updates through a small queue and raises redirect/flush on mispredict.
module riscv_branch_resolve #(
   parameter int UPD_FIFO_DEPTH = 4,
   parameter bit LINK_CHECK     = 1'b1
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [1:0]       ex_valid,
   input  logic [1:0]       ex_is_br,
   input  logic [1:0]       ex_is_jal,
   input  logic [1:0]       ex_is_jalr,
   input  logic [1:0][2:0]  ex_funct3,
   input  logic [1:0]       ex_rd_link,
   input  logic [1:0]       ex_rs1_link,
   input  logic [1:0][31:0] ex_pc,
   input  logic [1:0][31:0] ex_imm,
   input  logic [1:0][31:0] ex_rs1,
   input  logic [1:0][31:0] ex_rs2,
   input  logic [1:0][31:0] ex_pred_next,
   output logic             branch_occur,
   output logic             branch_taken,
   output logic             branch_nontaken,
   output logic             branch_call,
   output logic             branch_return,
   output logic             branch_jump,
   output logic [31:0]      branch_src,
   output logic [31:0]      branch_target,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   output logic             flush,
   output logic [31:0]      mispredict_cnt,
   output logic [15:0]      upd_drop_cnt
);

   localparam int PTR_W = (UPD_FIFO_DEPTH > 1) ? $clog2(UPD_FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] src;
      logic [31:0] target;
      logic        taken;
      logic        nontaken;
      logic        call;
      logic        ret;
      logic        jump;
   } upd_rec_t;

   typedef enum logic [0:0] {ST_IDLE, ST_REDIRECT} state_t;

   function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic r;
      case (f3)
         3'b000:  r = (a == b);
         3'b001:  r = (a != b);
         3'b100:  r = ($signed(a) < $signed(b));
         3'b101:  r = ($signed(a) >= $signed(b));
         3'b110:  r = (a < b);
         3'b111:  r = (a >= b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   logic [1:0]                taken_w;
   logic [1:0]                jump_w;
   logic [1:0]                mis_w;
   logic [1:0][31:0]          target_w;
   logic [1:0][31:0]          actual_w;
   upd_rec_t [1:0]            rec_w;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         logic [31:0] jalr_sum;
         logic        call_w;
         logic        ret_w;
         assign jalr_sum     = ex_rs1[gi] + ex_imm[gi];
         assign jump_w[gi]   = ex_is_jal[gi] | ex_is_jalr[gi];
         assign taken_w[gi]  = jump_w[gi] | (ex_is_br[gi] & br_cond(ex_funct3[gi], ex_rs1[gi], ex_rs2[gi]));
         assign target_w[gi] = ex_is_jalr[gi] ? {jalr_sum[31:1], 1'b0} : (ex_pc[gi] + ex_imm[gi]);
         assign actual_w[gi] = taken_w[gi] ? target_w[gi] : (ex_pc[gi] + 32'd4);
         assign mis_w[gi]    = (actual_w[gi] != ex_pred_next[gi]);
         assign call_w       = LINK_CHECK ? (jump_w[gi] & ex_rd_link[gi]) : 1'b0;
         assign ret_w        = LINK_CHECK ? (ex_is_jalr[gi] & ex_rs1_link[gi] & ~ex_rd_link[gi]) : 1'b0;
         assign rec_w[gi]    = '{src:      ex_pc[gi],
                                 target:   target_w[gi],
                                 taken:    taken_w[gi],
                                 nontaken: ex_is_br[gi] & ~taken_w[gi],
                                 call:     call_w,
                                 ret:      ret_w,
                                 jump:     jump_w[gi]};
      end
   endgenerate

   state_t      state_q, state_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        flush_q, flush_d;
   logic [31:0] mispredict_cnt_q, mispredict_cnt_d;
   logic        push0, push1;

   always_comb begin
      state_d          = state_q;
      redirect_pc_d    = redirect_pc_q;
      flush_d          = 1'b0;
      mispredict_cnt_d = mispredict_cnt_q;
      push0            = 1'b0;
      push1            = 1'b0;
      case (state_q)
         ST_IDLE: begin
            push0 = ex_valid[0];
            // A slot-0 mispredict makes slot 1 wrong-path: it neither trains nor redirects.
            push1 = ex_valid[1] & ~(ex_valid[0] & mis_w[0]);
            if (ex_valid[0] & mis_w[0]) begin
               state_d          = ST_REDIRECT;
               redirect_pc_d    = actual_w[0];
               flush_d          = 1'b1;
               mispredict_cnt_d = mispredict_cnt_q + 32'd1;
            end else if (push1 & mis_w[1]) begin
               state_d          = ST_REDIRECT;
               redirect_pc_d    = actual_w[1];
               flush_d          = 1'b1;
               mispredict_cnt_d = mispredict_cnt_q + 32'd1;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   upd_rec_t             mem_q [UPD_FIFO_DEPTH];
   upd_rec_t             mem_d [UPD_FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [15:0]          drop_cnt_q, drop_cnt_d;
   logic                 pop;
   logic [CNT_W-1:0]     free_w;
   logic [1:0]           n_req, accept, drops;
   logic [16:0]          drop_sum;
   upd_rec_t             first_rec;

   always_comb begin
      mem_d     = mem_q;
      pop       = (count_q != '0);
      // The head leaves this cycle regardless, so its slot is already reusable.
      free_w    = CNT_W'(UPD_FIFO_DEPTH) - count_q + CNT_W'(pop);
      n_req     = {1'b0, push0} + {1'b0, push1};
      accept    = (CNT_W'(n_req) > free_w) ? free_w[1:0] : n_req;
      drops     = n_req - accept;
      first_rec = push0 ? rec_w[0] : rec_w[1];
      if (accept != 2'd0) mem_d[wr_ptr_q] = first_rec;
      if (accept == 2'd2) mem_d[wr_ptr_q + PTR_W'(1)] = rec_w[1];
      wr_ptr_d  = wr_ptr_q + PTR_W'(accept);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
      count_d   = count_q - CNT_W'(pop) + CNT_W'(accept);
      drop_sum  = {1'b0, drop_cnt_q} + 17'(drops);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (srst) begin
         state_q          <= ST_IDLE;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         mispredict_cnt_q <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         drop_cnt_q       <= '0;
      end else begin
         state_q          <= state_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         mispredict_cnt_q <= mispredict_cnt_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         drop_cnt_q       <= drop_cnt_d;
      end
   end

   upd_rec_t head;
   assign head            = mem_q[rd_ptr_q];
   assign branch_occur    = pop;
   assign branch_taken    = pop & head.taken;
   assign branch_nontaken = pop & head.nontaken;
   assign branch_call     = pop & head.call;
   assign branch_return   = pop & head.ret;
   assign branch_jump     = pop & head.jump;
   assign branch_src      = pop ? head.src : 32'd0;
   assign branch_target   = pop ? head.target : 32'd0;

   assign redirect_valid  = (state_q == ST_REDIRECT);
   assign redirect_pc     = redirect_pc_q;
   assign flush           = flush_q;
   assign mispredict_cnt  = mispredict_cnt_q;
   assign upd_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_riscv_branch_resolve.sv
// Directed bench for riscv_branch_resolve: hand-computed expectations checked with immediate assertions.
module tb_riscv_branch_resolve;

   logic             clk;
   logic             srst;
   logic [1:0]       ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_rd_link, ex_rs1_link;
   logic [1:0][2:0]  ex_funct3;
   logic [1:0][31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_next;
   logic             branch_occur, branch_taken, branch_nontaken, branch_call, branch_return, branch_jump;
   logic [31:0]      branch_src, branch_target;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             redirect_ready;
   logic             flush;
   logic [31:0]      mispredict_cnt;
   logic [15:0]      upd_drop_cnt;

   int checks = 0;
   int errors = 0;

   riscv_branch_resolve #(.UPD_FIFO_DEPTH(4), .LINK_CHECK(1'b1)) dut (
      .clk(clk), .srst(srst),
      .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .ex_funct3(ex_funct3), .ex_rd_link(ex_rd_link), .ex_rs1_link(ex_rs1_link),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_next(ex_pred_next),
      .branch_occur(branch_occur), .branch_taken(branch_taken), .branch_nontaken(branch_nontaken),
      .branch_call(branch_call), .branch_return(branch_return), .branch_jump(branch_jump),
      .branch_src(branch_src), .branch_target(branch_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
      .flush(flush), .mispredict_cnt(mispredict_cnt), .upd_drop_cnt(upd_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_slots();
      ex_valid = '0; ex_is_br = '0; ex_is_jal = '0; ex_is_jalr = '0;
      ex_rd_link = '0; ex_rs1_link = '0; ex_funct3 = '0;
      ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0; ex_pred_next = '0;
   endtask

   // kind: 0 = branch, 1 = jal, 2 = jalr
   task automatic set_slot(input int s, input int kind, input logic [2:0] f3,
                           input logic rdl, input logic rs1l,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] pred);
      ex_valid[s]     = 1'b1;
      ex_is_br[s]     = (kind == 0);
      ex_is_jal[s]    = (kind == 1);
      ex_is_jalr[s]   = (kind == 2);
      ex_funct3[s]    = f3;
      ex_rd_link[s]   = rdl;
      ex_rs1_link[s]  = rs1l;
      ex_pc[s]        = pc;
      ex_imm[s]       = imm;
      ex_rs1[s]       = a;
      ex_rs2[s]       = b;
      ex_pred_next[s] = pred;
   endtask

   logic [31:0] fill_src [8];

   initial begin
      fill_src = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014, 32'h1018, 32'h1020};
      srst = 1'b1;
      redirect_ready = 1'b0;
      clear_slots();
      step();
      step();
      $display("txn reset");
      check("rst_occur", branch_occur, 0);
      check("rst_rvalid", redirect_valid, 0);
      check("rst_rpc", redirect_pc, 0);
      check("rst_flush", flush, 0);
      check("rst_mcnt", mispredict_cnt, 0);
      check("rst_drop", upd_drop_cnt, 0);
      srst = 1'b0;

      // BEQ taken, predicted correctly
      set_slot(0, 0, 3'b000, 0, 0, 32'h100, 32'h20, 5, 5, 32'h120);
      step(); clear_slots();
      $display("txn beq pc=0x100");
      check("beq_occur", branch_occur, 1);
      check("beq_taken", branch_taken, 1);
      check("beq_nontaken", branch_nontaken, 0);
      check("beq_target", branch_target, 32'h120);
      check("beq_src", branch_src, 32'h100);
      check("beq_rvalid", redirect_valid, 0);
      check("beq_flush", flush, 0);
      step();
      check("beq_drain", branch_occur, 0);

      // BLT signed: -1 < 1 taken
      set_slot(0, 0, 3'b100, 0, 0, 32'h200, 32'h40, 32'hFFFF_FFFF, 1, 32'h240);
      step(); clear_slots();
      $display("txn blt pc=0x200");
      check("blt_taken", branch_taken, 1);
      check("blt_target", branch_target, 32'h240);
      check("blt_rvalid", redirect_valid, 0);

      // BLTU: 0xFFFFFFFF < 1 false, predicted taken -> mispredict to pc+4
      set_slot(0, 0, 3'b110, 0, 0, 32'h200, 32'h40, 32'hFFFF_FFFF, 1, 32'h240);
      step(); clear_slots();
      $display("txn bltu pc=0x200");
      check("bltu_nontaken", branch_nontaken, 1);
      check("bltu_taken", branch_taken, 0);
      check("bltu_target", branch_target, 32'h240);
      check("bltu_rvalid", redirect_valid, 1);
      check("bltu_rpc", redirect_pc, 32'h204);
      check("bltu_flush", flush, 1);
      check("bltu_mcnt", mispredict_cnt, 1);
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      check("bltu_rvalid_drop", redirect_valid, 0);
      check("bltu_flush_1cyc", flush, 0);

      // JALR call: target (0x1001+2)&~1 = 0x1002
      set_slot(0, 2, 3'b000, 1, 0, 32'h300, 32'h2, 32'h1001, 0, 32'h304);
      step(); clear_slots();
      $display("txn jalr call pc=0x300");
      check("jalr_call", branch_call, 1);
      check("jalr_jump", branch_jump, 1);
      check("jalr_ret", branch_return, 0);
      check("jalr_target", branch_target, 32'h1002);
      check("jalr_rpc", redirect_pc, 32'h1002);
      check("jalr_flush", flush, 1);
      check("jalr_mcnt", mispredict_cnt, 2);
      // wrong-path mispredict while redirecting must be ignored
      set_slot(0, 0, 3'b000, 0, 0, 32'h900, 32'h10, 1, 1, 32'h904);
      step(); clear_slots();
      check("hold1_rvalid", redirect_valid, 1);
      check("hold1_rpc", redirect_pc, 32'h1002);
      check("hold1_flush", flush, 0);
      check("hold1_occur", branch_occur, 0);
      step();
      check("hold2_rpc", redirect_pc, 32'h1002);
      step();
      check("hold3_rvalid", redirect_valid, 1);
      check("hold3_rpc", redirect_pc, 32'h1002);
      redirect_ready = 1'b1;
      set_slot(0, 0, 3'b000, 0, 0, 32'h940, 32'h10, 1, 1, 32'h944);
      step(); clear_slots();
      redirect_ready = 1'b0;
      check("accept_rvalid", redirect_valid, 0);
      check("accept_flush", flush, 0);
      check("accept_mcnt", mispredict_cnt, 2);
      check("accept_occur", branch_occur, 0);

      // JALR return through x1, predicted correctly
      set_slot(0, 2, 3'b000, 0, 1, 32'h380, 32'h0, 32'h400, 0, 32'h400);
      step(); clear_slots();
      $display("txn jalr ret pc=0x380");
      check("ret_ret", branch_return, 1);
      check("ret_call", branch_call, 0);
      check("ret_target", branch_target, 32'h400);
      check("ret_rvalid", redirect_valid, 0);

      // Dual: slot 0 mispredicts, slot 1 discarded
      set_slot(0, 0, 3'b000, 0, 0, 32'h500, 32'h10, 1, 1, 32'h504);
      set_slot(1, 1, 3'b000, 0, 0, 32'h504, 32'h100, 0, 0, 32'h604);
      step(); clear_slots();
      $display("txn dual slot0 mispredict pc=0x500");
      check("d0_src", branch_src, 32'h500);
      check("d0_rpc", redirect_pc, 32'h510);
      check("d0_mcnt", mispredict_cnt, 3);
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      check("d0_slot1_dropped", branch_occur, 0);
      check("d0_rvalid", redirect_valid, 0);

      // Dual, both correct: updates at t+1 and t+2
      set_slot(0, 0, 3'b001, 0, 0, 32'h600, 32'h40, 1, 1, 32'h604);
      set_slot(1, 1, 3'b000, 0, 0, 32'h604, 32'h10, 0, 0, 32'h614);
      step(); clear_slots();
      $display("txn dual both correct pc=0x600");
      check("d1_src0", branch_src, 32'h600);
      check("d1_nontaken0", branch_nontaken, 1);
      step();
      check("d1_src1", branch_src, 32'h604);
      check("d1_jump1", branch_jump, 1);
      check("d1_target1", branch_target, 32'h614);
      check("d1_rvalid", redirect_valid, 0);
      step();
      check("d1_empty", branch_occur, 0);

      // Queue fill: five dual pushes into depth 4, last two cycles drop one each
      for (int k = 0; k < 5; k++) begin
         set_slot(0, 0, 3'b001, 0, 0, 32'h1000 + 32'(k * 8), 32'h40, 3, 3, 32'h1004 + 32'(k * 8));
         set_slot(1, 0, 3'b001, 0, 0, 32'h1004 + 32'(k * 8), 32'h40, 3, 3, 32'h1008 + 32'(k * 8));
         step();
         $display("txn fill %0d", k);
         check($sformatf("fill_src%0d", k), branch_src, fill_src[k]);
      end
      clear_slots();
      for (int k = 5; k < 8; k++) begin
         step();
         check($sformatf("fill_src%0d", k), branch_src, fill_src[k]);
      end
      check("fill_drop", upd_drop_cnt, 2);
      step();
      check("fill_empty", branch_occur, 0);

      // Slot 1 mispredicts, then reset while redirecting with slot-1 record queued
      set_slot(0, 0, 3'b000, 0, 0, 32'h700, 32'h40, 1, 2, 32'h704);
      set_slot(1, 1, 3'b000, 0, 0, 32'h704, 32'h20, 0, 0, 32'h708);
      step(); clear_slots();
      $display("txn slot1 mispredict pc=0x704");
      check("s1_rvalid", redirect_valid, 1);
      check("s1_rpc", redirect_pc, 32'h724);
      check("s1_src", branch_src, 32'h700);
      check("s1_mcnt", mispredict_cnt, 4);
      srst = 1'b1;
      step();
      srst = 1'b0;
      $display("txn reset mid-redirect");
      check("mrst_rvalid", redirect_valid, 0);
      check("mrst_occur", branch_occur, 0);
      check("mrst_mcnt", mispredict_cnt, 0);
      check("mrst_drop", upd_drop_cnt, 0);
      check("mrst_flush", flush, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
